// File: rtl/external_sm_hex_display_rx_if.sv
// external_sm_hex_display_rx_if: scanned 7-segment bus in, decoded 3-digit frame out
interface external_sm_hex_display_rx_if;
  logic [11:0] seven_segments;
  logic [3:0]  digit_out_1;
  logic [3:0]  digit_out_2;
  logic [3:0]  digit_out_3;
  logic [2:0]  dp_out;
  logic        frame_valid;
  logic        decode_err;
  logic        link_active;
  modport master (
    output seven_segments,
    input  digit_out_1, digit_out_2, digit_out_3, dp_out, frame_valid, decode_err, link_active
  );
  modport slave (
    input  seven_segments,
    output digit_out_1, digit_out_2, digit_out_3, dp_out, frame_valid, decode_err, link_active
  );
endinterface

// File: rtl/external_sm_hex_display_rx.sv
// external_sm_hex_display_rx: samples a multiplexed 3-digit 7-segment bus and rebuilds hex frames
module external_sm_hex_display_rx #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic                         clkIn,
  input logic                         rst_n,
  external_sm_hex_display_rx_if.slave bus
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [11:0]   sync_q, s_q, prev_q;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [2:0]    mask_q, mask_d, dps_q, dps_d, dpo_q, dpo_d, sel, mask_upd;
  logic [11:0]   nib_q, nib_d, dig_q, dig_d;
  logic          fv_q, fv_d, err_q, err_d, link_q, link_d;
  logic          legal, stable, capture, cap_ok, cap_bad, done, tmo_hit;
  logic [4:0]    dec;
  // returns {valid, nibble} for an active-high gfedcba pattern
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h10;
      7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;
      7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;
      7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;
      7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;
      7'h6F: decode = 5'h19;
      7'h77: decode = 5'h1A;
      7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;
      7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;
      7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction
  always_comb begin
    legal    = s_q[11] && (s_q[10:8] == 3'b110 || s_q[10:8] == 3'b101 || s_q[10:8] == 3'b011);
    stable   = legal && s_q == prev_q;
    settle_d = !stable ? '0 : (settle_q == SW'(SETTLE_CYCLES)) ? settle_q : settle_q + SW'(1);
    capture  = stable && settle_q == SW'(SETTLE_CYCLES - 1);
    sel      = ~s_q[10:8];
    dec      = decode(~s_q[6:0]);
    cap_ok   = capture && dec[4];
    cap_bad  = capture && !dec[4];
    nib_d    = nib_q;
    dps_d    = dps_q;
    for (int k = 0; k < 3; k++)
      if (cap_ok && sel[k]) begin
        nib_d[4*k +: 4] = dec[3:0];
        dps_d[k]        = ~s_q[7];
      end
    mask_upd = mask_q | sel;
    done     = cap_ok && mask_upd == 3'b111;
    // the counter parks at TIMEOUT_CYCLES so the link-down event fires only once
    tmo_hit  = !cap_ok && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    tmo_d    = cap_ok ? '0 : (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TW'(1);
    mask_d   = (cap_bad || done || tmo_hit) ? 3'b000 : cap_ok ? mask_upd : mask_q;
    dig_d    = done ? nib_d : dig_q;
    dpo_d    = done ? dps_d : dpo_q;
    fv_d     = done;
    err_d    = cap_bad;
    link_d   = done ? 1'b1 : tmo_hit ? 1'b0 : link_q;
  end
  always_ff @(posedge clkIn) begin
    if (!rst_n) begin
      sync_q   <= '1;
      s_q      <= '1;
      prev_q   <= '1;
      settle_q <= '0;
      tmo_q    <= '0;
      mask_q   <= '0;
      nib_q    <= '0;
      dps_q    <= '0;
      dig_q    <= '0;
      dpo_q    <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      link_q   <= 1'b0;
    end else begin
      sync_q   <= bus.seven_segments;
      s_q      <= sync_q;
      prev_q   <= s_q;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      mask_q   <= mask_d;
      nib_q    <= nib_d;
      dps_q    <= dps_d;
      dig_q    <= dig_d;
      dpo_q    <= dpo_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      link_q   <= link_d;
    end
  end
  assign bus.digit_out_1 = dig_q[3:0];
  assign bus.digit_out_2 = dig_q[7:4];
  assign bus.digit_out_3 = dig_q[11:8];
  assign bus.dp_out      = dpo_q;
  assign bus.frame_valid = fv_q;
  assign bus.decode_err  = err_q;
  assign bus.link_active = link_q;
endmodule
